// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared FSM state and response encodings for the write arbiter
package axi_lite_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_wr_arbiter_if.sv
// axi_lite_wr_arbiter_if: one AXI4-Lite write port (AW, W, B channels)
interface axi_lite_wr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant decision with a registered priority pointer
module rr_arbiter_2 (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_idx
);
  logic ptr;
  // on contention take the favoured requester, otherwise whichever is asking
  always_comb gnt_idx = (&req) ? ptr : req[1];
  // after each decision the requester just granted loses priority
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) ptr <= 1'b0;
    else if (update) ptr <= ~gnt_idx;
endmodule

// File: rtl/axi_lite_wr_arbiter.sv
// axi_lite_wr_arbiter: shares one AXI4-Lite write path between two masters, one write in flight
module axi_lite_wr_arbiter
  import axi_lite_pkg::*;
(
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_lite_wr_arbiter_if.slave  s0,
  axi_lite_wr_arbiter_if.slave  s1,
  axi_lite_wr_arbiter_if.master m,
  output logic                  grant,
  output logic                  busy
);
  state_t state, state_d;
  logic grant_d, aw_done, aw_done_d, w_done, w_done_d;
  logic gnt_idx, upd, in_addr, in_resp;
  logic g_awvalid, g_wvalid, g_bready;
  logic aw_rdy, w_rdy, b_vld, aw_hs, w_hs, b_hs;

  rr_arbiter_2 u_rr (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .req     ({s1.awvalid, s0.awvalid}),
    .update  (upd),
    .gnt_idx (gnt_idx)
  );

  assign in_addr   = state == ADDR;
  assign in_resp   = state == RESP;
  assign busy      = state != IDLE;
  assign upd       = (state == IDLE) & (s0.awvalid | s1.awvalid);
  assign g_awvalid = grant ? s1.awvalid : s0.awvalid;
  assign g_wvalid  = grant ? s1.wvalid : s0.wvalid;
  assign g_bready  = grant ? s1.bready : s0.bready;

  assign m.awvalid = in_addr & g_awvalid & ~aw_done;
  assign m.awaddr  = in_addr ? (grant ? s1.awaddr : s0.awaddr) : '0;
  assign m.wvalid  = in_addr & g_wvalid & ~w_done;
  assign m.wdata   = in_addr ? (grant ? s1.wdata : s0.wdata) : '0;
  assign m.wstrb   = in_addr ? (grant ? s1.wstrb : s0.wstrb) : '0;
  assign m.bready  = in_resp & g_bready;

  assign aw_rdy = in_addr & m.awready & ~aw_done;
  assign w_rdy  = in_addr & m.wready & ~w_done;
  assign b_vld  = in_resp & m.bvalid;

  assign s0.awready = aw_rdy & ~grant;
  assign s1.awready = aw_rdy & grant;
  assign s0.wready  = w_rdy & ~grant;
  assign s1.wready  = w_rdy & grant;
  assign s0.bvalid  = b_vld & ~grant;
  assign s1.bvalid  = b_vld & grant;
  assign s0.bresp   = (in_resp & ~grant) ? m.bresp : OKAY;
  assign s1.bresp   = (in_resp & grant) ? m.bresp : OKAY;

  assign aw_hs = m.awvalid & m.awready;
  assign w_hs  = m.wvalid & m.wready;
  assign b_hs  = m.bvalid & m.bready;

  // next state: grant on AW request, wait for both AW and W, then for the B handshake
  always_comb begin
    state_d   = state;
    grant_d   = grant;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    case (state)
      IDLE: if (upd) begin
        state_d = ADDR;
        grant_d = gnt_idx;
      end
      ADDR: if ((aw_done | aw_hs) & (w_done | w_hs)) begin
        state_d   = RESP;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end else begin
        aw_done_d = aw_done | aw_hs;
        w_done_d  = w_done | w_hs;
      end
      RESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, grant and per-channel completion flags
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state   <= IDLE;
      grant   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      aw_done <= aw_done_d;
      w_done  <= w_done_d;
    end
endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// tb_axi_lite_wr_arbiter: directed and randomized writes checked against a transaction-level model
module tb_axi_lite_wr_arbiter;
  import axi_lite_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b1;
  logic grant, busy;
  int checks = 0;
  int failures = 0;
  bit exp_ptr;
  bit pend [2];
  logic [31:0] addr [2];
  logic [31:0] data [2];
  logic [3:0]  strb [2];

  axi_lite_wr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
  axi_lite_wr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();
  axi_lite_wr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  axi_lite_wr_arbiter dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s0      (s0_if),
    .s1      (s1_if),
    .m       (m_if),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_s(input int n, input string tag, input logic awr, input logic wr,
                         input logic bv, input logic [1:0] br);
    check($sformatf("%s_s%0d_awready", tag, n), n ? s1_if.awready : s0_if.awready, awr);
    check($sformatf("%s_s%0d_wready", tag, n), n ? s1_if.wready : s0_if.wready, wr);
    check($sformatf("%s_s%0d_bvalid", tag, n), n ? s1_if.bvalid : s0_if.bvalid, bv);
    check($sformatf("%s_s%0d_bresp", tag, n), n ? s1_if.bresp : s0_if.bresp, br);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_m_awvalid"}, m_if.awvalid, 0);
    check({tag, "_m_wvalid"}, m_if.wvalid, 0);
    check({tag, "_m_bready"}, m_if.bready, 0);
    check({tag, "_m_awaddr"}, m_if.awaddr, 0);
    check({tag, "_m_wdata"}, m_if.wdata, 0);
    check_s(0, tag, 0, 0, 0, OKAY);
    check_s(1, tag, 0, 0, 0, OKAY);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_s(input int n, input logic av, input logic wv, input logic br);
    if (n == 0) begin
      s0_if.awvalid = av; s0_if.awaddr = addr[0];
      s0_if.wvalid = wv;  s0_if.wdata = data[0]; s0_if.wstrb = strb[0];
      s0_if.bready = br;
    end else begin
      s1_if.awvalid = av; s1_if.awaddr = addr[1];
      s1_if.wvalid = wv;  s1_if.wdata = data[1]; s1_if.wstrb = strb[1];
      s1_if.bready = br;
    end
  endtask

  task automatic clear_inputs();
    drive_s(0, 0, 0, 0);
    drive_s(1, 0, 0, 0);
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = OKAY;
  endtask

  task automatic do_reset();
    ARESETn = 0;
    clear_inputs();
    pend[0] = 0; pend[1] = 0; exp_ptr = 0;
    @(negedge ACLK);
    check_zero("reset");
    tick();
    ARESETn = 1;
  endtask

  task automatic load(input int n, input bit rnd);
    if (rnd) begin
      addr[n] = $urandom; data[n] = $urandom; strb[n] = 4'($urandom);
    end
    pend[n] = 1;
    drive_s(n, 1, 1, 0);
  endtask

  // one arbitrated write: called in IDLE with requests already driven
  task automatic run_write(input int aw_wait, input int w_wait, input int b_wait,
                           input logic [1:0] resp, input bit abort);
    int g, cyc;
    bit aw_seen, w_seen;
    g = (pend[0] && pend[1]) ? int'(exp_ptr) : (pend[1] ? 1 : 0);
    aw_seen = 0; w_seen = 0; cyc = 0;
    m_if.awready = 1; m_if.wready = 1;
    @(negedge ACLK);
    check("idle_busy", busy, 0);
    check("idle_m_awvalid", m_if.awvalid, 0);
    check("idle_m_wvalid", m_if.wvalid, 0);
    check_s(0, "idle", 0, 0, 0, OKAY);
    check_s(1, "idle", 0, 0, 0, OKAY);
    tick();
    exp_ptr = (g == 0);
    while (!(aw_seen && w_seen)) begin
      m_if.awready = cyc >= aw_wait;
      m_if.wready = cyc >= w_wait;
      @(negedge ACLK);
      check("addr_busy", busy, 1);
      check("addr_grant", grant, g);
      check("addr_m_awvalid", m_if.awvalid, !aw_seen);
      check("addr_m_wvalid", m_if.wvalid, !w_seen);
      check("addr_m_awaddr", m_if.awaddr, addr[g]);
      check("addr_m_wdata", m_if.wdata, data[g]);
      check("addr_m_wstrb", m_if.wstrb, strb[g]);
      check("addr_m_bready", m_if.bready, 0);
      check_s(g, "addr", m_if.awready && !aw_seen, m_if.wready && !w_seen, 0, OKAY);
      check_s(1 - g, "addr_other", 0, 0, 0, OKAY);
      aw_seen = aw_seen | m_if.awready;
      w_seen = w_seen | m_if.wready;
      cyc++;
      tick();
    end
    pend[g] = 0;
    m_if.bvalid = 1; m_if.bresp = resp;
    for (int i = 0; i <= b_wait; i++) begin
      drive_s(g, 0, 0, i == b_wait);
      @(negedge ACLK);
      check("resp_busy", busy, 1);
      check("resp_grant", grant, g);
      check("resp_m_awvalid", m_if.awvalid, 0);
      check("resp_m_wvalid", m_if.wvalid, 0);
      check("resp_m_awaddr", m_if.awaddr, 0);
      check("resp_m_wdata", m_if.wdata, 0);
      check("resp_m_bready", m_if.bready, i == b_wait);
      check_s(g, "resp", 0, 0, 1, resp);
      check_s(1 - g, "resp_other", 0, 0, 0, OKAY);
      if (abort) begin
        #1 ARESETn = 0;
        #1 check_zero("abort");
        clear_inputs();
        pend[0] = 0; pend[1] = 0; exp_ptr = 0;
        tick();
        ARESETn = 1;
        return;
      end
      tick();
    end
    m_if.bvalid = 0; m_if.bresp = OKAY;
    drive_s(g, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr[i] = 0; data[i] = 0; strb[i] = 0; pend[i] = 0;
    end
    clear_inputs();
    do_reset();
    addr[0] = 32'h10; data[0] = 32'hDEADBEEF; strb[0] = 4'hF;
    load(0, 0);
    run_write(0, 0, 0, OKAY, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (!pend[0]) load(0, 1);
      if (!pend[1]) load(1, 1);
      run_write(0, 0, 0, OKAY, 0);
    end
    run_write(0, 0, 0, OKAY, 0);
    addr[1] = $urandom; data[1] = $urandom; strb[1] = 4'($urandom);
    drive_s(1, 0, 1, 0);
    m_if.awready = 1; m_if.wready = 1;
    repeat (2) begin
      @(negedge ACLK);
      check("earlyw_busy", busy, 0);
      check("earlyw_m_wvalid", m_if.wvalid, 0);
      check_s(1, "earlyw", 0, 0, 0, OKAY);
      tick();
    end
    load(1, 0);
    run_write(0, 0, 0, OKAY, 0);
    load(0, 1);
    load(1, 1);
    run_write(0, 0, 2, SLVERR, 0);
    run_write(0, 3, 0, OKAY, 0);
    for (int i = 0; i < 8; i++) begin
      if (!pend[0] && $urandom_range(0, 1) == 1) load(0, 1);
      if (!pend[1] && $urandom_range(0, 1) == 1) load(1, 1);
      if (!pend[0] && !pend[1]) load(int'($urandom_range(0, 1)), 1);
      run_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                ($urandom_range(0, 1) == 1) ? SLVERR : OKAY, 0);
    end
    while (pend[0] || pend[1]) run_write(0, 0, 0, OKAY, 0);
    if (!exp_ptr) begin
      load(0, 1);
      run_write(0, 0, 0, OKAY, 0);
    end
    load(0, 1);
    load(1, 1);
    run_write(1, 0, 1, OKAY, 1);
    load(0, 1);
    load(1, 1);
    run_write(0, 0, 0, OKAY, 0);
    run_write(0, 0, 0, OKAY, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
